// File: rtl/vs_ascii_hex_parser.sv
// ASCII hex-number parser: accumulates hex digits MSB-first from a UART byte stream
// and publishes the value when the terminator arrives; backspace removes the last digit.
module vs_ascii_hex_parser #(
    parameter int          DIGITS = 4,
    parameter logic [7:0]  TERM   = 8'h0D,
    parameter logic [7:0]  BKSP   = 8'h08,
    localparam int         W      = 4 * DIGITS,
    localparam int         CW     = $clog2(DIGITS + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [7:0]    rx_data_i,
    input  logic          rx_valid_i,
    output logic [W-1:0]  value_o,
    output logic          value_valid_o,
    output logic [CW-1:0] digit_count_o,
    output logic          err_o,
    output logic          busy_o,
    output logic [1:0]    state_dbg_o
);

    // Handshake: rx_valid_i is a one-cycle strobe qualifying rx_data_i; there is no
    // ready, so every strobed byte is consumed on the cycle it is presented.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  value_q, value_d;
    logic [CW-1:0] count_q, count_d;
    logic          vv_q, vv_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;

    logic          is_hex;
    logic [3:0]    nib;

    always_comb begin
        is_hex = 1'b0;
        nib    = 4'd0;
        if (rx_data_i >= 8'h30 && rx_data_i <= 8'h39) begin
            is_hex = 1'b1;
            nib    = rx_data_i[3:0];
        end else if ((rx_data_i >= 8'h41 && rx_data_i <= 8'h46) ||
                     (rx_data_i >= 8'h61 && rx_data_i <= 8'h66)) begin
            // 'A'/'a' have low nibble 1, so adding 9 maps A..F onto 10..15.
            is_hex = 1'b1;
            nib    = rx_data_i[3:0] + 4'd9;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        value_d = value_q;
        count_d = count_q;
        vv_d    = 1'b0;
        err_d   = 1'b0;
        if (rx_valid_i) begin
            case (state_q)
                IDLE: begin
                    if (is_hex) begin
                        acc_d   = (acc_q << 4) | W'(nib);
                        cnt_d   = cnt_q + 1'b1;
                        state_d = ACCUM;
                    end else if (rx_data_i != TERM && rx_data_i != BKSP) begin
                        err_d   = 1'b1;
                        state_d = DISCARD;
                    end
                end
                ACCUM: begin
                    if (is_hex) begin
                        if (cnt_q == CW'(DIGITS)) begin
                            err_d   = 1'b1;
                            state_d = DISCARD;
                        end else begin
                            acc_d = (acc_q << 4) | W'(nib);
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else if (rx_data_i == BKSP) begin
                        acc_d = acc_q >> 4;
                        cnt_d = cnt_q - 1'b1;
                        if (cnt_q == CW'(1)) begin
                            state_d = IDLE;
                        end
                    end else if (rx_data_i == TERM) begin
                        value_d = acc_q;
                        count_d = cnt_q;
                        vv_d    = 1'b1;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = DISCARD;
                    end
                end
                DISCARD: begin
                    if (rx_data_i == TERM) begin
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            value_q <= '0;
            count_q <= '0;
            vv_q    <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            value_q <= value_d;
            count_q <= count_d;
            vv_q    <= vv_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign value_o       = value_q;
    assign value_valid_o = vv_q;
    assign digit_count_o = count_q;
    assign err_o         = err_q;
    assign busy_o        = busy_q;
    assign state_dbg_o   = state_q;

endmodule
